// File: rtl/pipe_pkg.sv
// Shared constants for the write-back pipeline stage: default payload
// widths, the deepest legal slot chain, and the occupancy-width helper.
package pipe_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int RD_W_DEF   = 6;
    localparam int DEPTH_MAX  = 4;

    // Bits needed to count 0..depth valid slots.
    function automatic int occ_w(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_wb_stage_if.sv
// Input bundle of the write-back stage: pipeline control, the incoming
// instruction payload and the two forwarding query indices.
// Handshake: there is no backpressure. On every rising clk edge with
// flush=0 and stall=0 the stage accepts the payload whatever validIn is;
// validIn=0 marks that accepted entry as a bubble.
interface pipe_wb_stage_if #(
    parameter int DATA_W = pipe_pkg::DATA_W_DEF,
    parameter int RD_W   = pipe_pkg::RD_W_DEF
);
    logic              stall;
    logic              flush;
    logic              validIn;
    logic              regWriteIn;
    logic              memToRegIn;
    logic              zeroIn;
    logic              negIn;
    logic [DATA_W-1:0] memDataIn;
    logic [DATA_W-1:0] aluResultIn;
    logic [RD_W-1:0]   rdIn;
    logic [RD_W-1:0]   qRs;
    logic [RD_W-1:0]   qRt;

    // Producer of instructions and queries.
    modport master (
        output stall, flush, validIn, regWriteIn, memToRegIn, zeroIn, negIn,
        output memDataIn, aluResultIn, rdIn, qRs, qRt
    );

    // The stage receiving them.
    modport slave (
        input stall, flush, validIn, regWriteIn, memToRegIn, zeroIn, negIn,
        input memDataIn, aluResultIn, rdIn, qRs, qRt
    );
endinterface

// File: rtl/pipe_wb_stage_slot.sv
// One pipeline slot: a valid bit plus the write-back payload. Clear wins
// over load; with neither asserted the slot holds.
module pipe_wb_slot
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_W   = RD_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic              d_valid,
    input  logic              d_reg_write,
    input  logic              d_mem_to_reg,
    input  logic              d_zero,
    input  logic              d_neg,
    input  logic [DATA_W-1:0] d_mem_data,
    input  logic [DATA_W-1:0] d_alu_result,
    input  logic [RD_W-1:0]   d_rd,
    output logic              q_valid,
    output logic              q_reg_write,
    output logic              q_mem_to_reg,
    output logic              q_zero,
    output logic              q_neg,
    output logic [DATA_W-1:0] q_mem_data,
    output logic [DATA_W-1:0] q_alu_result,
    output logic [RD_W-1:0]   q_rd
);

    logic              valid_q, valid_d;
    logic              reg_write_q, reg_write_d;
    logic              mem_to_reg_q, mem_to_reg_d;
    logic              zero_q, zero_d;
    logic              neg_q, neg_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic [DATA_W-1:0] alu_result_q, alu_result_d;
    logic [RD_W-1:0]   rd_q, rd_d;

    // Next-state select: clear, load, or hold.
    always_comb begin
        valid_d      = valid_q;
        reg_write_d  = reg_write_q;
        mem_to_reg_d = mem_to_reg_q;
        zero_d       = zero_q;
        neg_d        = neg_q;
        mem_data_d   = mem_data_q;
        alu_result_d = alu_result_q;
        rd_d         = rd_q;
        if (clear) begin
            valid_d      = 1'b0;
            reg_write_d  = 1'b0;
            mem_to_reg_d = 1'b0;
            zero_d       = 1'b0;
            neg_d        = 1'b0;
            mem_data_d   = '0;
            alu_result_d = '0;
            rd_d         = '0;
        end else if (load) begin
            valid_d      = d_valid;
            reg_write_d  = d_reg_write;
            mem_to_reg_d = d_mem_to_reg;
            zero_d       = d_zero;
            neg_d        = d_neg;
            mem_data_d   = d_mem_data;
            alu_result_d = d_alu_result;
            rd_d         = d_rd;
        end
    end

    // Slot registers, asynchronously cleared by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            zero_q       <= 1'b0;
            neg_q        <= 1'b0;
            mem_data_q   <= '0;
            alu_result_q <= '0;
            rd_q         <= '0;
        end else begin
            valid_q      <= valid_d;
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            zero_q       <= zero_d;
            neg_q        <= neg_d;
            mem_data_q   <= mem_data_d;
            alu_result_q <= alu_result_d;
            rd_q         <= rd_d;
        end
    end

    assign q_valid      = valid_q;
    assign q_reg_write  = reg_write_q;
    assign q_mem_to_reg = mem_to_reg_q;
    assign q_zero       = zero_q;
    assign q_neg        = neg_q;
    assign q_mem_data   = mem_data_q;
    assign q_alu_result = alu_result_q;
    assign q_rd         = rd_q;

endmodule

// File: rtl/pipe_wb_stage.sv
// Write-back pipeline stage: a chain of DEPTH slots (slot 0 youngest,
// slot DEPTH-1 drives the outputs) with stall/flush control, qualified
// outputs, youngest-first register forwarding and an occupancy count.
module pipe_wb_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_W   = RD_W_DEF,
    parameter int DEPTH  = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      validIn,
    input  logic                      regWriteIn,
    input  logic                      memToRegIn,
    input  logic                      zeroIn,
    input  logic                      negIn,
    input  logic [DATA_W-1:0]         memDataIn,
    input  logic [DATA_W-1:0]         aluResultIn,
    input  logic [RD_W-1:0]           rdIn,
    output logic                      validOut,
    output logic                      regWriteOut,
    output logic                      memToRegOut,
    output logic                      zeroOut,
    output logic                      negOut,
    output logic [DATA_W-1:0]         memDataOut,
    output logic [DATA_W-1:0]         aluResultOut,
    output logic [RD_W-1:0]           rdOut,
    output logic [DATA_W-1:0]         wbData,
    input  logic [RD_W-1:0]           qRs,
    input  logic [RD_W-1:0]           qRt,
    output logic                      fwdHitRs,
    output logic                      fwdHitRt,
    output logic [DATA_W-1:0]         fwdDataRs,
    output logic [DATA_W-1:0]         fwdDataRt,
    output logic [occ_w(DEPTH)-1:0]   occupancy
);

    localparam int OCC_W = occ_w(DEPTH);

    logic              s_valid      [DEPTH];
    logic              s_reg_write  [DEPTH];
    logic              s_mem_to_reg [DEPTH];
    logic              s_zero       [DEPTH];
    logic              s_neg        [DEPTH];
    logic [DATA_W-1:0] s_mem_data   [DEPTH];
    logic [DATA_W-1:0] s_alu_result [DEPTH];
    logic [RD_W-1:0]   s_rd         [DEPTH];

    // Flush beats stall; stall freezes the whole chain.
    logic load, clear;
    assign clear = flush;
    assign load  = !stall && !flush;

    // A write to r0 or from a bubble is never a real write.
    logic in_reg_write;
    assign in_reg_write = regWriteIn && validIn && (rdIn != '0);

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        if (i == 0) begin : g_head
            pipe_wb_slot #(.DATA_W(DATA_W), .RD_W(RD_W)) u_slot (
                .clk(clk), .rst(rst), .load(load), .clear(clear),
                .d_valid(validIn), .d_reg_write(in_reg_write),
                .d_mem_to_reg(memToRegIn), .d_zero(zeroIn), .d_neg(negIn),
                .d_mem_data(memDataIn), .d_alu_result(aluResultIn), .d_rd(rdIn),
                .q_valid(s_valid[i]), .q_reg_write(s_reg_write[i]),
                .q_mem_to_reg(s_mem_to_reg[i]), .q_zero(s_zero[i]), .q_neg(s_neg[i]),
                .q_mem_data(s_mem_data[i]), .q_alu_result(s_alu_result[i]), .q_rd(s_rd[i])
            );
        end else begin : g_tail
            pipe_wb_slot #(.DATA_W(DATA_W), .RD_W(RD_W)) u_slot (
                .clk(clk), .rst(rst), .load(load), .clear(clear),
                .d_valid(s_valid[i-1]), .d_reg_write(s_reg_write[i-1]),
                .d_mem_to_reg(s_mem_to_reg[i-1]), .d_zero(s_zero[i-1]), .d_neg(s_neg[i-1]),
                .d_mem_data(s_mem_data[i-1]), .d_alu_result(s_alu_result[i-1]), .d_rd(s_rd[i-1]),
                .q_valid(s_valid[i]), .q_reg_write(s_reg_write[i]),
                .q_mem_to_reg(s_mem_to_reg[i]), .q_zero(s_zero[i]), .q_neg(s_neg[i]),
                .q_mem_data(s_mem_data[i]), .q_alu_result(s_alu_result[i]), .q_rd(s_rd[i])
            );
        end
    end

    // Oldest slot drives the outputs, forced to zero when it holds a bubble.
    always_comb begin
        validOut     = s_valid[DEPTH-1];
        regWriteOut  = validOut ? s_reg_write[DEPTH-1]  : 1'b0;
        memToRegOut  = validOut ? s_mem_to_reg[DEPTH-1] : 1'b0;
        zeroOut      = validOut ? s_zero[DEPTH-1]       : 1'b0;
        negOut       = validOut ? s_neg[DEPTH-1]        : 1'b0;
        memDataOut   = validOut ? s_mem_data[DEPTH-1]   : '0;
        aluResultOut = validOut ? s_alu_result[DEPTH-1] : '0;
        rdOut        = validOut ? s_rd[DEPTH-1]         : '0;
        wbData       = memToRegOut ? memDataOut : aluResultOut;
    end

    // Forwarding lookup: scan oldest to youngest so the youngest match wins.
    always_comb begin
        fwdHitRs  = 1'b0;
        fwdHitRt  = 1'b0;
        fwdDataRs = '0;
        fwdDataRt = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (s_valid[i] && s_reg_write[i] && (qRs != '0) && (s_rd[i] == qRs)) begin
                fwdHitRs  = 1'b1;
                fwdDataRs = s_mem_to_reg[i] ? s_mem_data[i] : s_alu_result[i];
            end
            if (s_valid[i] && s_reg_write[i] && (qRt != '0) && (s_rd[i] == qRt)) begin
                fwdHitRt  = 1'b1;
                fwdDataRt = s_mem_to_reg[i] ? s_mem_data[i] : s_alu_result[i];
            end
        end
    end

    // Number of slots currently holding a real instruction.
    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OCC_W'(s_valid[i]);
        end
    end

endmodule

// File: tb/tb_pipe_wb_stage.sv
// Directed bench for pipe_wb_stage: three instances (DEPTH 1, 2, 3) share
// one input bundle; each scenario task drives vectors and checks inline.
module tb_pipe_wb_stage;

    localparam int DW = 32;
    localparam int RW = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_wb_stage_if #(.DATA_W(DW), .RD_W(RW)) bus ();

    logic          v_o    [1:3];
    logic          rw_o   [1:3];
    logic          m2r_o  [1:3];
    logic          z_o    [1:3];
    logic          n_o    [1:3];
    logic [DW-1:0] md_o   [1:3];
    logic [DW-1:0] alu_o  [1:3];
    logic [RW-1:0] rd_o   [1:3];
    logic [DW-1:0] wb_o   [1:3];
    logic          hit_rs [1:3];
    logic          hit_rt [1:3];
    logic [DW-1:0] fd_rs  [1:3];
    logic [DW-1:0] fd_rt  [1:3];
    logic [0:0]    occ1;
    logic [1:0]    occ2;
    logic [1:0]    occ3;

    int passed = 0;
    int total  = 0;

    pipe_wb_stage #(.DATA_W(DW), .RD_W(RW), .DEPTH(1)) u_d1 (
        .clk(clk), .rst(rst), .stall(bus.stall), .flush(bus.flush),
        .validIn(bus.validIn), .regWriteIn(bus.regWriteIn), .memToRegIn(bus.memToRegIn),
        .zeroIn(bus.zeroIn), .negIn(bus.negIn), .memDataIn(bus.memDataIn),
        .aluResultIn(bus.aluResultIn), .rdIn(bus.rdIn),
        .validOut(v_o[1]), .regWriteOut(rw_o[1]), .memToRegOut(m2r_o[1]),
        .zeroOut(z_o[1]), .negOut(n_o[1]), .memDataOut(md_o[1]),
        .aluResultOut(alu_o[1]), .rdOut(rd_o[1]), .wbData(wb_o[1]),
        .qRs(bus.qRs), .qRt(bus.qRt), .fwdHitRs(hit_rs[1]), .fwdHitRt(hit_rt[1]),
        .fwdDataRs(fd_rs[1]), .fwdDataRt(fd_rt[1]), .occupancy(occ1)
    );

    pipe_wb_stage #(.DATA_W(DW), .RD_W(RW), .DEPTH(2)) u_d2 (
        .clk(clk), .rst(rst), .stall(bus.stall), .flush(bus.flush),
        .validIn(bus.validIn), .regWriteIn(bus.regWriteIn), .memToRegIn(bus.memToRegIn),
        .zeroIn(bus.zeroIn), .negIn(bus.negIn), .memDataIn(bus.memDataIn),
        .aluResultIn(bus.aluResultIn), .rdIn(bus.rdIn),
        .validOut(v_o[2]), .regWriteOut(rw_o[2]), .memToRegOut(m2r_o[2]),
        .zeroOut(z_o[2]), .negOut(n_o[2]), .memDataOut(md_o[2]),
        .aluResultOut(alu_o[2]), .rdOut(rd_o[2]), .wbData(wb_o[2]),
        .qRs(bus.qRs), .qRt(bus.qRt), .fwdHitRs(hit_rs[2]), .fwdHitRt(hit_rt[2]),
        .fwdDataRs(fd_rs[2]), .fwdDataRt(fd_rt[2]), .occupancy(occ2)
    );

    pipe_wb_stage #(.DATA_W(DW), .RD_W(RW), .DEPTH(3)) u_d3 (
        .clk(clk), .rst(rst), .stall(bus.stall), .flush(bus.flush),
        .validIn(bus.validIn), .regWriteIn(bus.regWriteIn), .memToRegIn(bus.memToRegIn),
        .zeroIn(bus.zeroIn), .negIn(bus.negIn), .memDataIn(bus.memDataIn),
        .aluResultIn(bus.aluResultIn), .rdIn(bus.rdIn),
        .validOut(v_o[3]), .regWriteOut(rw_o[3]), .memToRegOut(m2r_o[3]),
        .zeroOut(z_o[3]), .negOut(n_o[3]), .memDataOut(md_o[3]),
        .aluResultOut(alu_o[3]), .rdOut(rd_o[3]), .wbData(wb_o[3]),
        .qRs(bus.qRs), .qRt(bus.qRt), .fwdHitRs(hit_rs[3]), .fwdHitRt(hit_rt[3]),
        .fwdDataRs(fd_rs[3]), .fwdDataRt(fd_rt[3]), .occupancy(occ3)
    );

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_in(input logic v, input logic rw, input logic m2r,
                          input logic [DW-1:0] md, input logic [DW-1:0] alu,
                          input logic [RW-1:0] rd);
        bus.validIn     = v;
        bus.regWriteIn  = rw;
        bus.memToRegIn  = m2r;
        bus.zeroIn      = 1'b0;
        bus.negIn       = 1'b0;
        bus.memDataIn   = md;
        bus.aluResultIn = alu;
        bus.rdIn        = rd;
    endtask

    task automatic set_q(input logic [RW-1:0] rs, input logic [RW-1:0] rt);
        bus.qRs = rs;
        bus.qRt = rt;
        #1;
    endtask

    task automatic clear_pipe();
        bus.stall = 1'b0;
        bus.flush = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, '0, '0, '0);
        tick();
        bus.flush = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        set_in(1'b1, 1'b1, 1'b1, 32'hDEAD, 32'hBEEF, 6'd9);
        bus.zeroIn = 1'b1;
        bus.negIn  = 1'b1;
        set_q(6'd9, 6'd9);
        tick();
        tick();
        for (int d = 1; d <= 3; d++) begin
            total++;
            if ({v_o[d], rw_o[d], m2r_o[d], z_o[d], n_o[d], md_o[d], alu_o[d], rd_o[d],
                 wb_o[d], hit_rs[d], hit_rt[d], fd_rs[d], fd_rt[d]} !== '0)
                $display("FAIL reset_outputs d%0d: got v=%0b rd=%0d wb=%h hit=%0b want all 0",
                         d, v_o[d], rd_o[d], wb_o[d], hit_rs[d]);
            else passed++;
        end
        total++;
        if ({occ1, occ2, occ3} !== 5'd0) $display("FAIL reset_occ: got %b want 0", {occ1, occ2, occ3});
        else passed++;
        rst = 1'b0;
    endtask

    task automatic test_single();
        clear_pipe();
        set_in(1'b1, 1'b1, 1'b0, 32'h5555, 32'h1234, 6'd5);
        bus.zeroIn = 1'b1;
        bus.negIn  = 1'b1;
        tick();
        total++; if (v_o[1] !== 1'b1) $display("FAIL single_valid: got %0b want 1", v_o[1]); else passed++;
        total++; if (rd_o[1] !== 6'd5) $display("FAIL single_rd: got %0d want 5", rd_o[1]); else passed++;
        total++; if (wb_o[1] !== 32'h1234) $display("FAIL single_wb: got %h want 1234", wb_o[1]); else passed++;
        total++; if ({rw_o[1], z_o[1], n_o[1]} !== 3'b111) $display("FAIL single_flags: got %b want 111", {rw_o[1], z_o[1], n_o[1]}); else passed++;
        set_in(1'b1, 1'b1, 1'b1, 32'hBEEF, 32'h0001, 6'd8);
        tick();
        set_q(6'd8, 6'd5);
        total++; if (wb_o[1] !== 32'hBEEF) $display("FAIL load_wb: got %h want beef", wb_o[1]); else passed++;
        total++; if ({m2r_o[1], md_o[1], alu_o[1]} !== {1'b1, 32'hBEEF, 32'h1}) $display("FAIL load_payload: got %0b %h %h want 1 beef 1", m2r_o[1], md_o[1], alu_o[1]); else passed++;
        total++; if ({hit_rs[1], fd_rs[1]} !== {1'b1, 32'hBEEF}) $display("FAIL load_fwd_rs: got %0b %h want 1 beef", hit_rs[1], fd_rs[1]); else passed++;
        total++; if ({hit_rt[1], fd_rt[1]} !== {1'b0, 32'h0}) $display("FAIL load_fwd_rt: got %0b %h want 0 0", hit_rt[1], fd_rt[1]); else passed++;
        set_in(1'b0, 1'b1, 1'b1, 32'h7777, 32'h8888, 6'd3);
        tick();
        total++; if ({v_o[1], rw_o[1], rd_o[1], wb_o[1], occ1} !== '0) $display("FAIL bubble_out: got v=%0b rw=%0b rd=%0d wb=%h occ=%0d want 0", v_o[1], rw_o[1], rd_o[1], wb_o[1], occ1); else passed++;
    endtask

    task automatic test_back_to_back();
        clear_pipe();
        set_q(6'd7, 6'd3);
        set_in(1'b1, 1'b1, 1'b0, '0, 32'hA, 6'd7); tick();
        set_in(1'b1, 1'b1, 1'b0, '0, 32'hB, 6'd7); tick();
        set_in(1'b1, 1'b1, 1'b0, '0, 32'hC, 6'd7); tick();
        total++; if ({hit_rs[3], fd_rs[3]} !== {1'b1, 32'hC}) $display("FAIL b2b_fwd_rs: got %0b %h want 1 c", hit_rs[3], fd_rs[3]); else passed++;
        total++; if (occ3 !== 2'd3) $display("FAIL b2b_occ: got %0d want 3", occ3); else passed++;
        total++; if ({hit_rt[3], fd_rt[3]} !== {1'b0, 32'h0}) $display("FAIL b2b_fwd_rt_miss: got %0b %h want 0 0", hit_rt[3], fd_rt[3]); else passed++;
        total++; if ({rd_o[3], wb_o[3]} !== {6'd7, 32'hA}) $display("FAIL b2b_latency: got %0d %h want 7 a", rd_o[3], wb_o[3]); else passed++;
        set_in(1'b1, 1'b1, 1'b1, 32'h77, 32'h99, 6'd3); tick();
        total++; if ({hit_rt[3], fd_rt[3]} !== {1'b1, 32'h77}) $display("FAIL b2b_fwd_rt_load: got %0b %h want 1 77", hit_rt[3], fd_rt[3]); else passed++;
        total++; if ({fd_rs[3], wb_o[3]} !== {32'hC, 32'hB}) $display("FAIL b2b_shift: got %h %h want c b", fd_rs[3], wb_o[3]); else passed++;
        set_in(1'b0, 1'b0, 1'b0, '0, '0, 6'd7); tick();
        total++; if (occ3 !== 2'd2) $display("FAIL b2b_bubble_occ: got %0d want 2", occ3); else passed++;
        total++; if ({fd_rs[3], fd_rt[3], wb_o[3]} !== {32'hC, 32'h77, 32'hC}) $display("FAIL b2b_bubble_fwd: got %h %h %h want c 77 c", fd_rs[3], fd_rt[3], wb_o[3]); else passed++;
    endtask

    task automatic test_stall();
        clear_pipe();
        set_in(1'b1, 1'b1, 1'b0, '0, 32'h111, 6'd9);  tick();
        set_in(1'b1, 1'b1, 1'b0, '0, 32'h222, 6'd10); tick();
        total++; if ({rd_o[2], wb_o[2], occ2} !== {6'd9, 32'h111, 2'd2}) $display("FAIL stall_pre: got %0d %h %0d want 9 111 2", rd_o[2], wb_o[2], occ2); else passed++;
        bus.stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_in(1'b1, 1'b1, k[0], 32'h500 + k, 32'h300 + k, 6'(20 + k));
            tick();
            total++;
            if ({v_o[2], rd_o[2], wb_o[2], occ2} !== {1'b1, 6'd9, 32'h111, 2'd2})
                $display("FAIL stall_hold%0d: got %0b %0d %h %0d want 1 9 111 2", k, v_o[2], rd_o[2], wb_o[2], occ2);
            else passed++;
        end
        bus.stall = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, '0, '0, '0);
        tick();
        total++; if ({v_o[2], rd_o[2], wb_o[2], occ2} !== {1'b1, 6'd10, 32'h222, 2'd1}) $display("FAIL stall_release: got %0b %0d %h %0d want 1 10 222 1", v_o[2], rd_o[2], wb_o[2], occ2); else passed++;
        tick();
        total++; if ({v_o[2], occ2} !== 3'b000) $display("FAIL stall_drain: got %0b %0d want 0 0", v_o[2], occ2); else passed++;
    endtask

    task automatic test_flush_stall();
        clear_pipe();
        set_in(1'b1, 1'b1, 1'b0, '0, 32'h44, 6'd4); tick();
        set_in(1'b1, 1'b1, 1'b0, '0, 32'h55, 6'd5); tick();
        set_q(6'd4, 6'd5);
        total++; if ({occ2, hit_rs[2], fd_rs[2], hit_rt[2], fd_rt[2]} !== {2'd2, 1'b1, 32'h44, 1'b1, 32'h55}) $display("FAIL flush_pre: got %0d %0b %h %0b %h want 2 1 44 1 55", occ2, hit_rs[2], fd_rs[2], hit_rt[2], fd_rt[2]); else passed++;
        bus.stall = 1'b1;
        bus.flush = 1'b1;
        set_in(1'b1, 1'b1, 1'b0, '0, 32'h66, 6'd4);
        tick();
        total++; if ({occ2, v_o[2], hit_rs[2], hit_rt[2]} !== 5'd0) $display("FAIL flush_over_stall: got occ=%0d v=%0b hrs=%0b hrt=%0b want 0", occ2, v_o[2], hit_rs[2], hit_rt[2]); else passed++;
        total++; if ({occ1, occ3} !== 3'd0) $display("FAIL flush_all: got %0d %0d want 0 0", occ1, occ3); else passed++;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
    endtask

    task automatic test_rd_zero();
        clear_pipe();
        set_q(6'd0, 6'd0);
        set_in(1'b1, 1'b1, 1'b0, '0, 32'h55, 6'd0);
        tick();
        total++; if ({v_o[1], rw_o[1], wb_o[1]} !== {1'b1, 1'b0, 32'h55}) $display("FAIL rd0_out: got v=%0b rw=%0b wb=%h want 1 0 55", v_o[1], rw_o[1], wb_o[1]); else passed++;
        total++; if ({hit_rs[1], fd_rs[1], hit_rt[1]} !== '0) $display("FAIL rd0_fwd: got %0b %h %0b want 0", hit_rs[1], fd_rs[1], hit_rt[1]); else passed++;
    endtask

    task automatic test_async_reset();
        clear_pipe();
        set_in(1'b1, 1'b1, 1'b0, '0, 32'h21, 6'd2); tick();
        set_in(1'b1, 1'b1, 1'b0, '0, 32'h31, 6'd3); tick();
        set_q(6'd3, 6'd2);
        total++; if ({occ2, hit_rs[2], rd_o[2]} !== {2'd2, 1'b1, 6'd2}) $display("FAIL areset_pre: got %0d %0b %0d want 2 1 2", occ2, hit_rs[2], rd_o[2]); else passed++;
        #1 rst = 1'b1;
        #1;
        for (int d = 2; d <= 3; d++) begin
            total++;
            if ({v_o[d], rw_o[d], m2r_o[d], z_o[d], n_o[d], md_o[d], alu_o[d], rd_o[d],
                 wb_o[d], hit_rs[d], hit_rt[d], fd_rs[d], fd_rt[d]} !== '0)
                $display("FAIL areset_immediate d%0d: got v=%0b rd=%0d wb=%h hit=%0b want all 0",
                         d, v_o[d], rd_o[d], wb_o[d], hit_rs[d]);
            else passed++;
        end
        total++; if ({occ2, occ3} !== 4'd0) $display("FAIL areset_occ: got %0d %0d want 0 0", occ2, occ3); else passed++;
        set_in(1'b1, 1'b1, 1'b0, '0, 32'h66, 6'd6);
        tick();
        total++; if ({v_o[1], occ1} !== 2'b00) $display("FAIL areset_held: got %0b %0d want 0 0", v_o[1], occ1); else passed++;
        rst = 1'b0;
        tick();
        total++; if ({v_o[1], rd_o[1], wb_o[1]} !== {1'b1, 6'd6, 32'h66}) $display("FAIL areset_resume: got %0b %0d %h want 1 6 66", v_o[1], rd_o[1], wb_o[1]); else passed++;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, '0, '0, '0);
        bus.qRs = '0;
        bus.qRt = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_flush_stall();
        test_rd_zero();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pipe_wb_stage.md
PIPE_WB_STAGE -- requirements
Module: pipe_wb_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning width of memory-data and ALU-result payloads.
REQ-002 SHALL have parameter RD_W, default 6, meaning destination-register index width.
REQ-003 SHALL have parameter DEPTH, default 1, legal 1..4, meaning number of chained register slots (latency in cycles).
REQ-004 SHALL have ports, in this order:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold all slots.
- flush  in  1  invalidate all slots.
- validIn  in  1  input slot carries an instruction.
- regWriteIn  in  1  write-back enable.
- memToRegIn  in  1  write-back source select.
- zeroIn  in  1  ALU zero flag.
- negIn  in  1  ALU negative flag.
- memDataIn  in  DATA_W  load data.
- aluResultIn  in  DATA_W  ALU result.
- rdIn  in  RD_W  destination index.
- validOut  out  1  oldest slot valid.
- regWriteOut  out  1  oldest-slot write enable, qualified.
- memToRegOut  out  1  oldest-slot select, qualified.
- zeroOut  out  1  oldest-slot zero flag, qualified.
- negOut  out  1  oldest-slot negative flag, qualified.
- memDataOut  out  DATA_W  oldest-slot load data.
- aluResultOut  out  DATA_W  oldest-slot ALU result.
- rdOut  out  RD_W  oldest-slot destination.
- wbData  out  DATA_W  memToRegOut ? memDataOut : aluResultOut.
- qRs, qRt  in  RD_W  forwarding query indices.
- fwdHitRs, fwdHitRt  out  1  query matched an in-flight write.
- fwdDataRs, fwdDataRt  out  DATA_W  forwarded value.
- occupancy  out  clog2(DEPTH+1)  count of valid slots.

Function
REQ-005 SHALL shift all slots one position per rising clk edge when stall=0 and flush=0; slot 0 captures the inputs, and slot DEPTH-1 drives the outputs.
REQ-006 SHALL give input-to-output latency of exactly DEPTH cycles with no stalls.
REQ-007 SHALL hold every slot unchanged on an edge with stall=1 and flush=0, and SHALL ignore the inputs on that edge.
REQ-008 SHALL clear every slot's valid on an edge with flush=1, regardless of stall; flush SHALL take priority over stall.
REQ-009 SHALL store a slot's regWrite as regWriteIn AND validIn AND (rdIn != 0).
REQ-010 SHALL force regWriteOut, memToRegOut, zeroOut, negOut, memDataOut, aluResultOut, rdOut and wbData to 0 while validOut=0.
REQ-011 SHALL compute the forwarding outputs combinationally: a slot matches a query when it is valid, its regWrite=1 and its rd equals the query index.
REQ-012 SHALL, when several slots match, take the youngest match (lowest slot index) for the forwarded value.
REQ-013 SHALL make the forwarded value equal to that slot's write-back value (memData if memToReg, else aluResult).
REQ-014 SHALL drive fwdHit=0 and fwdData=0 when no slot matches; a query of 0 SHALL never hit.
REQ-015 SHALL make occupancy equal the number of valid slots after each edge; flush SHALL yield 0 on the next cycle.
REQ-016 SHALL treat the inputs as a bubble when validIn=0; the bubble still advances and still occupies a slot position.

Reset
REQ-017 SHALL, while rst=1, asynchronously clear every slot's valid and every slot's payload to 0.
REQ-018 SHALL hold all outputs at 0 while rst=1, including occupancy=0 and fwdHit=0.
REQ-019 SHALL resume shifting on the first rising clk edge after rst deasserts; rst mid-stall or mid-flush SHALL have the same effect.

Structure
REQ-020 SHALL place the default widths (DATA_W=32, RD_W=6) and the maximum DEPTH constant in shared package pipe_pkg.
REQ-021 SHALL implement one slot as sub-module pipe_wb_slot (valid plus payload register with load, hold and clear), instantiated DEPTH times by generate.

Verification
REQ-022 SHALL cover: DEPTH=1, validIn=1, regWriteIn=1, rdIn=5, aluResultIn=0x1234, memToRegIn=0 -> next cycle validOut=1, rdOut=5, wbData=0x1234.
REQ-023 SHALL cover: DEPTH=3, three back-to-back writes to rd=7 with ALU values 0xA, 0xB, 0xC, qRs=7 -> after the third edge fwdDataRs=0xC and fwdHitRs=1; occupancy=3.
REQ-024 SHALL cover: DEPTH=2, stall=1 for 4 cycles with changing inputs -> outputs and occupancy unchanged; on release the held instruction emerges.
REQ-025 SHALL cover: stall=1 and flush=1 on the same edge with occupancy=2 -> next cycle occupancy=0, validOut=0, fwdHitRs=fwdHitRt=0.
REQ-026 SHALL cover: a write with rdIn=0 and regWriteIn=1 -> regWriteOut=0 at output; qRs=0 gives fwdHitRs=0.
REQ-027 SHALL cover: rst asserted between clock edges with occupancy=2 -> all outputs 0 immediately, without waiting for clk.
